// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Multi-byte frames hold the grant until the requester's last byte is issued.
module uart_tx_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int UART_DATA_WIDTH = 8,
   parameter int ACTIVE_TIMEOUT  = 4   // must be >= 2
) (
   input  logic                               i_Clock,
   input  logic                               i_Rst_n,
   input  logic [NUM_REQ-1:0]                 i_Req_Valid,
   input  logic [NUM_REQ-1:0]                 i_Req_Last,
   input  logic [NUM_REQ*UART_DATA_WIDTH-1:0] i_Req_Byte,
   output logic [NUM_REQ-1:0]                 o_Req_Ready,
   output logic                               o_Tx_DV,
   output logic [UART_DATA_WIDTH-1:0]         o_Tx_Byte,
   input  logic                               i_Tx_Active,
   input  logic                               i_Tx_Done,
   output logic [$clog2(NUM_REQ)-1:0]         o_Grant_Id,
   output logic                               o_Busy,
   output logic                               o_Timeout
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(ACTIVE_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACTIVE, S_WAIT_DONE, S_COOLDOWN
   } state_t;

   state_t                     state_q, state_d;
   logic [GW-1:0]              ptr_q, ptr_d;
   logic [GW-1:0]              grant_q, grant_d;
   logic                       lock_q, lock_d;
   logic [UART_DATA_WIDTH-1:0] byte_q, byte_d;
   logic [NUM_REQ-1:0]         ready_q, ready_d;
   logic                       dv_q, dv_d;
   logic                       busy_q, busy_d;
   logic                       timeout_q, timeout_d;
   logic [CW-1:0]              cnt_q, cnt_d;

   logic [UART_DATA_WIDTH-1:0] req_byte [NUM_REQ];
   logic [GW-1:0]              rr_idx;
   logic [GW-1:0]              rr_win;
   logic                       rr_hit;
   logic [GW-1:0]              take_id;
   logic                       take;
   logic [GW-1:0]              ptr_inc;
   logic                       cnt_expire;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_byte[gi] = i_Req_Byte[gi*UART_DATA_WIDTH +: UART_DATA_WIDTH];
      end
   endgenerate

   // Walk from the farthest candidate back to ptr so the closest valid one wins.
   always_comb begin
      rr_win = ptr_q;
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         rr_idx = GW'((int'(ptr_q) + i) % NUM_REQ);
         if (i_Req_Valid[rr_idx]) begin
            rr_win = rr_idx;
            rr_hit = 1'b1;
         end
      end
   end

   assign take_id    = lock_q ? grant_q : rr_win;
   assign take       = lock_q ? i_Req_Valid[grant_q] : rr_hit;
   assign ptr_inc    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
   assign cnt_expire = (cnt_q + CW'(1)) == CW'(ACTIVE_TIMEOUT - 1);

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:        if (take) state_d = S_ISSUE;
         S_ISSUE:       state_d = S_WAIT_ACTIVE;
         S_WAIT_ACTIVE: begin
            if (i_Tx_Active)     state_d = S_WAIT_DONE;
            else if (cnt_expire) state_d = S_IDLE;
         end
         S_WAIT_DONE:   if (i_Tx_Done) state_d = S_COOLDOWN;
         S_COOLDOWN:    if (!i_Tx_Done && !i_Tx_Active) state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      lock_d    = lock_q;
      byte_d    = byte_q;
      cnt_d     = cnt_q;
      ready_d   = '0;
      dv_d      = 1'b0;
      timeout_d = 1'b0;
      busy_d    = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (take) begin
               byte_d  = req_byte[take_id];
               grant_d = take_id;
               lock_d  = ~i_Req_Last[take_id];
               ready_d = NUM_REQ'(1) << take_id;
               dv_d    = 1'b1;
            end
         end
         S_ISSUE: cnt_d = '0;
         S_WAIT_ACTIVE: begin
            if (!i_Tx_Active) begin
               if (cnt_expire) begin
                  // Byte is abandoned; release any frame lock so others can proceed.
                  timeout_d = 1'b1;
                  lock_d    = 1'b0;
                  ptr_d     = ptr_inc;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_COOLDOWN: begin
            if (!i_Tx_Done && !i_Tx_Active && !lock_q) ptr_d = ptr_inc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ptr_q     <= '0;
         grant_q   <= '0;
         lock_q    <= 1'b0;
         byte_q    <= '0;
         cnt_q     <= '0;
         ready_q   <= '0;
         dv_q      <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         lock_q    <= lock_d;
         byte_q    <= byte_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         dv_q      <= dv_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign o_Req_Ready = ready_q;
   assign o_Tx_DV     = dv_q;
   assign o_Tx_Byte   = byte_q;
   assign o_Grant_Id  = grant_q;
   assign o_Busy      = busy_q;
   assign o_Timeout   = timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` instance between `NUM_REQ` byte producers, such as the adder result path and status/debug sources. It accepts bytes over a valid/ready handshake and drives the transmitter's `i_Tx_DV`/`i_Tx_Byte`. It sequences each byte through the transmitter's busy/done indications. Multi-byte frames are kept contiguous by locking the grant until the requester's last byte.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `UART_DATA_WIDTH`, 8: byte width.
- `ACTIVE_TIMEOUT`, 4: cycles allowed between `o_Tx_DV` and `i_Tx_Active` rising.
- `i_Clock` input 1: system clock.
- `i_Rst_n` input 1: reset, one clock domain, asynchronous and active-low.
- `i_Req_Valid` input NUM_REQ: per-requester byte valid.
- `i_Req_Last` input NUM_REQ: byte is the last of its frame.
- `i_Req_Byte` input NUM_REQ*UART_DATA_WIDTH: requester k occupies bits [k*W +: W].
- `o_Req_Ready` output NUM_REQ: one-cycle accept pulse, at most one bit set.
- `o_Tx_DV` output 1: one-cycle start pulse to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte` output UART_DATA_WIDTH: to `uart_tx` `i_Tx_Byte`; held stable from capture to next capture.
- `i_Tx_Active` input 1: from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done` input 1: from `uart_tx` `o_Tx_Done`.
- `o_Grant_Id` output $clog2(NUM_REQ): current or last granted requester.
- `o_Busy` output 1: high in every state except IDLE.
- `o_Timeout` output 1: one-cycle pulse when `ACTIVE_TIMEOUT` expires.

## Operation
- All outputs are registered.
- The round-robin pointer `ptr` resets to 0. The lock flag resets to 0.
- The arbiter is a state machine with states IDLE, ISSUE, WAIT_ACTIVE, WAIT_DONE and COOLDOWN.
- IDLE, unlocked:
  - Search `i_Req_Valid` starting at `ptr` and wrapping modulo NUM_REQ.
  - The first set bit, g, wins.
  - On that edge, capture `i_Req_Byte[g]` into `o_Tx_Byte`, set `o_Grant_Id`=g, capture lock = ~`i_Req_Last[g]`, and go to ISSUE.
  - If no valid bit is set, stay in IDLE.
- IDLE, locked:
  - Only requester `o_Grant_Id` is considered. Other requesters wait indefinitely.
  - If its valid is set, capture as above. If not, stay in IDLE with the lock held.
- ISSUE lasts exactly one cycle:
  - `o_Tx_DV`=1 and `o_Req_Ready[g]`=1 during this cycle.
  - The requester must hold valid and byte stable until it sees ready. It may change them on the edge ending ISSUE.
  - Next state is WAIT_ACTIVE; the timeout counter clears.
- WAIT_ACTIVE:
  - If `i_Tx_Active`=1, go to WAIT_DONE.
  - If the counter reaches `ACTIVE_TIMEOUT`-1 first, pulse `o_Timeout` for 1 cycle, clear the lock, set `ptr`=g+1 mod NUM_REQ, and go to IDLE. The byte is considered lost.
- WAIT_DONE: wait for `i_Tx_Done`=1, then go to COOLDOWN.
- COOLDOWN:
  - Wait until `i_Tx_Done`=0 and `i_Tx_Active`=0. This covers `uart_tx`, which holds done high for 2 cycles.
  - Then go to IDLE.
  - If the lock is clear, `ptr` = g+1 mod NUM_REQ.
- `ptr` never advances while the lock is held.
- `uart_tx` has no reset. If `i_Rst_n` is asserted mid-byte, the arbiter returns to reset state, but the transmitter finishes its byte. The first post-reset issue may then time out; that is required and acceptable behaviour.

## Timing
- Reset values: `o_Req_Ready`=0, `o_Tx_DV`=0, `o_Tx_Byte`=0, `o_Grant_Id`=0, `o_Busy`=0, `o_Timeout`=0.
- Latency: valid sampled high in IDLE at edge N gives `o_Tx_DV`/`o_Req_Ready` high during cycle N+1, and `o_Busy` high from N+1.
- Per byte, arbiter overhead beyond `uart_tx` frame time is ≤ 3 cycles: issue, plus return to IDLE after done clears.
- Back-to-back bytes from one locked requester are contiguous frames, with no extra idle bit times beyond `uart_tx` cleanup.
- Simultaneous valid bits are resolved by `ptr` only. Ties never favour a fixed index.
- Valid deasserted before ready is a protocol violation; the captured byte is still sent.

## Test plan
- Single byte: req1 sends 0xA5, last=1.
  - Expect `o_Tx_DV` for exactly one cycle, with `o_Req_Ready`=4'b0010 in the same cycle.
  - Expect `o_Tx_Byte`=0xA5, and `o_Busy` falls 1-2 cycles after done clears.
- Round-robin: all 4 requesters valid with last=1 and bytes 0x10..0x13 from reset.
  - Grant order 0,1,2,3.
  - Then requesters 0 and 3 re-request; grant order is 0, then 3.
- Frame lock: req2 sends 0x01,0x02,0x03 with last only on 0x03, while req0 is held valid.
  - Expect 3 consecutive req2 grants, then req0.
  - Req2 valid dropping between bytes must keep req0 blocked.
- Timeout: hold `i_Tx_Active`=0 after issue.
  - Expect `o_Timeout` pulse exactly `ACTIVE_TIMEOUT` cycles after `o_Tx_DV`.
  - Expect return to IDLE and `ptr` advanced.
- Reset mid-frame: assert `i_Rst_n`=0 during WAIT_DONE of a locked frame.
  - Expect all outputs at reset values immediately (asynchronously).
  - Expect lock cleared and next grant from index 0.
- With real `uart_tx` (`r_config_data`=437): 2 requesters, 2 bytes each.
  - The serial line decodes all 4 bytes in grant order.
  - No byte is overlapped or dropped.
